opb_reg_slave_arb: RTL and testbench
====================================

// Module: opb_reg_slave_arb
// PURPOSE
//  Decodes one OPB master transaction onto N software-register slaves (opb_register_simulink2ppc
//  instances, e.g. gbe txfullctr/rxctr) sharing one address window of fixed-size slots.
//  Issues registered per-slot selects, returns the selected slave's data/ack on the upstream OPB,
//  and terminates unanswered accesses with errAck after a timeout. Sits between the EPB/OPB
//  bridge and the register bank of a 10GbE (tge) subsystem.
// PARAMETERS
//  C_BASEADDR    32'h010C0000  byte address of slot 0
//  C_SLOT_BITS   8             log2 slot size in bytes (256 B per register)
//  N_SLAVES      8             number of slots/slaves, 1..16
//  C_TIMEOUT     16            cycles ACTIVE may last before errAck, >=2
//  C_OPB_AWIDTH  32            address width
//  C_OPB_DWIDTH  32            data width
// PORTS
//  OPB_Clk      in   1        bus clock, all logic on rising edge
//  OPB_Rst      in   1        asynchronous, active-high reset
//  OPB_ABus     in   [0:31]   master address
//  OPB_BE       in   [0:3]    byte enables, forwarded
//  OPB_DBus     in   [0:31]   write data, forwarded
//  OPB_RNW      in   1        1=read
//  OPB_select   in   1        transaction valid
//  OPB_seqAddr  in   1        ignored (single beats only)
//  Sl_DBus      out  [0:31]   read data, zero unless acking a read
//  Sl_errAck    out  1        error termination pulse
//  Sl_retry     out  1        tied 0
//  Sl_toutSup   out  1        bus-timeout suppress while ACTIVE
//  Sl_xferAck   out  1        transfer-complete pulse
//  S_select     out  N_SLAVES one-hot slave select
//  S_ABus/S_DBus/S_BE/S_RNW out 32/32/4/1  registered copies of master fields
//  S_rdata      in   N_SLAVES*32  slave read data, slot k at [32k+31:32k]
//  S_xferAck    in   N_SLAVES  slave acks
//  err_count    out  16       saturating count of timeouts
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, err_count 0; reset mid-transaction drops S_select with no ack.
//  - slot = (OPB_ABus - C_BASEADDR) >> C_SLOT_BITS; hit = OPB_select & addr>=BASE & slot<N_SLAVES.
//  - IDLE: on hit, latch slot, ABus, DBus, BE, RNW; next cycle S_select[slot]=1 -> ACTIVE, tmr=0.
//    Miss: no response at all (another slave owns it).
//  - ACTIVE: S_select held, Sl_toutSup=1, tmr++ each cycle.
//    S_xferAck[slot]=1: next cycle Sl_xferAck=1 for exactly 1 cycle, Sl_DBus=S_rdata[slot] if RNW
//    else 0; S_select drops same edge -> DONE.
//    tmr==C_TIMEOUT-1 and no ack: next cycle Sl_errAck=1 (1 cycle), err_count+1 (sat 0xFFFF) -> DONE.
//    Ack and timeout same cycle: ack wins, no errAck, no count.
//    Acks from non-selected slots ignored.
//    OPB_select low (master abort): -> IDLE next cycle, S_select cleared, no ack, no count.
//  - DONE: one cycle, all responses 0, -> IDLE (master drops select after ack; no re-decode).
//  - Read latency: hit to Sl_xferAck = slave ack latency + 2 cycles.
//  - Sl_DBus, Sl_xferAck, Sl_errAck never asserted outside the single termination cycle (OR-bus).
// STRUCTURE
//  - Shared include opb_arb_defs.vh: state encodings IDLE/ACTIVE/DONE, SLOT_W = clog2(N_SLAVES).
//  - Single flat module; timeout counter and data mux inline, no sub-module.
// TESTING
//  - Read slot 3 (addr 0x010C0300), slave acks after 2 cycles with 0xDEADBEEF -> S_select=0x08,
//    one-cycle Sl_xferAck, Sl_DBus=0xDEADBEEF that cycle only, 0 elsewhere.
//  - Write 0x12345678 to 0x010C0104 BE=4'hF -> S_select=0x02, S_DBus=0x12345678, Sl_DBus=0 at ack.
//  - Read 0x010C0500 with no slave ack, C_TIMEOUT=16 -> Sl_errAck 1 cycle, err_count 0->1, no xferAck.
//  - Access 0x010C0800 (N_SLAVES=8) and 0x010B0000 -> no S_select, no ack, no errAck.
//  - Slave 2 acks on the exact timeout cycle -> xferAck only, err_count unchanged;
//    stray ack from slot 5 while slot 2 is selected -> ignored.
//  - OPB_Rst asserted while ACTIVE -> S_select=0 immediately, no ack; next access works normally.

Source files
------------

// File: rtl/opb_reg_slave_arb_pkg.sv
// Shared definitions for the OPB register-slave arbiter.
// Holds the FSM state encodings and the slot-index width helper.
package opb_reg_slave_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int ERR_W = 16;

  // A single slave still needs a one-bit slot register.
  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/opb_reg_slave_arb.sv
// Decodes one OPB master transaction onto N software-register slots, forwards the
// selected slave's ack/data upstream, and terminates silent slaves with errAck.
module opb_reg_slave_arb
  import opb_reg_slave_arb_pkg::*;
#(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter int                      C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h010C0000,
  parameter int                      C_SLOT_BITS  = 8,
  parameter int                      N_SLAVES     = 8,
  parameter int                      C_TIMEOUT    = 16
) (
  input  logic                             OPB_Clk,
  input  logic                             OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]          OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]        OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]          OPB_DBus,
  input  logic                             OPB_RNW,
  input  logic                             OPB_select,
  input  logic                             OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]          Sl_DBus,
  output logic                             Sl_errAck,
  output logic                             Sl_retry,
  output logic                             Sl_toutSup,
  output logic                             Sl_xferAck,
  output logic [N_SLAVES-1:0]              S_select,
  output logic [0:C_OPB_AWIDTH-1]          S_ABus,
  output logic [0:C_OPB_DWIDTH-1]          S_DBus,
  output logic [0:C_OPB_DWIDTH/8-1]        S_BE,
  output logic                             S_RNW,
  input  logic [N_SLAVES*C_OPB_DWIDTH-1:0] S_rdata,
  input  logic [N_SLAVES-1:0]              S_xferAck,
  output logic [ERR_W-1:0]                 err_count
);

  localparam int                      SLOT_W      = slot_width(N_SLAVES);
  localparam int                      TMR_W       = $clog2(C_TIMEOUT) + 1;
  localparam logic [C_OPB_AWIDTH-1:0] LP_NSLOT    = C_OPB_AWIDTH'(N_SLAVES);
  localparam logic [TMR_W-1:0]        LP_TMR_LAST = TMR_W'(C_TIMEOUT - 1);

  logic [1:0]                  r_state;
  logic [SLOT_W-1:0]           r_slot;
  logic [N_SLAVES-1:0]         r_sel;
  logic [TMR_W-1:0]            r_tmr;
  logic [C_OPB_AWIDTH-1:0]     r_abus;
  logic [C_OPB_DWIDTH-1:0]     r_wdata;
  logic [C_OPB_DWIDTH/8-1:0]   r_be;
  logic                        r_rnw;
  logic [C_OPB_DWIDTH-1:0]     r_dbus;
  logic                        r_xfer_ack;
  logic                        r_err_ack;
  logic [ERR_W-1:0]            r_err_count;

  logic [C_OPB_AWIDTH-1:0]     w_offset;
  logic [C_OPB_AWIDTH-1:0]     w_slot_full;
  logic [SLOT_W-1:0]           w_slot;
  logic                        w_hit;
  logic                        w_sel_ack;
  logic [C_OPB_DWIDTH-1:0]     w_rdata [N_SLAVES];
  logic                        w_unused;

  // The subtraction wraps below the base, so the >= test is what rejects those.
  assign w_offset    = OPB_ABus - C_BASEADDR;
  assign w_slot_full = w_offset >> C_SLOT_BITS;
  assign w_slot      = w_slot_full[SLOT_W-1:0];
  assign w_hit       = OPB_select && (OPB_ABus >= C_BASEADDR) && (w_slot_full < LP_NSLOT);

  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_rdata
      assign w_rdata[gi] = S_rdata[gi*C_OPB_DWIDTH +: C_OPB_DWIDTH];
    end
  endgenerate

  assign w_sel_ack = S_xferAck[r_slot];
  assign w_unused  = ^{OPB_seqAddr, w_offset};

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_state     <= ST_IDLE;
      r_slot      <= '0;
      r_sel       <= '0;
      r_tmr       <= '0;
      r_abus      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rnw       <= 1'b0;
      r_dbus      <= '0;
      r_xfer_ack  <= 1'b0;
      r_err_ack   <= 1'b0;
      r_err_count <= '0;
    end else begin
      // Upstream responses are single-cycle pulses on a wired-OR bus.
      r_xfer_ack <= 1'b0;
      r_err_ack  <= 1'b0;
      r_dbus     <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_state <= ST_ACTIVE;
            r_slot  <= w_slot;
            r_sel   <= N_SLAVES'(1) << w_slot;
            r_tmr   <= '0;
            r_abus  <= OPB_ABus;
            r_wdata <= OPB_DBus;
            r_be    <= OPB_BE;
            r_rnw   <= OPB_RNW;
          end
        end
        ST_ACTIVE: begin
          if (!OPB_select) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
          end else if (w_sel_ack) begin
            r_xfer_ack <= 1'b1;
            r_dbus     <= r_rnw ? w_rdata[r_slot] : '0;
            r_sel      <= '0;
            r_state    <= ST_DONE;
          end else if (r_tmr == LP_TMR_LAST) begin
            r_err_ack <= 1'b1;
            if (r_err_count != {ERR_W{1'b1}}) begin
              r_err_count <= r_err_count + 1'b1;
            end
            r_sel   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Sl_DBus    = r_dbus;
  assign Sl_xferAck = r_xfer_ack;
  assign Sl_errAck  = r_err_ack;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = (r_state == ST_ACTIVE);
  assign S_select   = r_sel;
  assign S_ABus     = r_abus;
  assign S_DBus     = r_wdata;
  assign S_BE       = r_be;
  assign S_RNW      = r_rnw;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_opb_reg_slave_arb.sv
// Directed bench for opb_reg_slave_arb: a per-cycle expectation timeline built from
// transaction-level rules, compared against the DUT on every falling edge.
module tb_opb_reg_slave_arb;

  localparam int DEPTH = 1024;
  localparam int TMO   = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:31]  abus;
  logic [0:3]   be;
  logic [0:31]  dbus_m;
  logic         rnw;
  logic         sel;
  logic         seq;
  logic [0:31]  sl_dbus;
  logic         sl_err;
  logic         sl_retry;
  logic         sl_tout;
  logic         sl_xfer;
  logic [7:0]   s_sel;
  logic [0:31]  s_abus;
  logic [0:31]  s_dbus;
  logic [0:3]   s_be;
  logic         s_rnw;
  logic [255:0] s_rdata;
  logic [7:0]   s_ack;
  logic [15:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_cnt = 0;

  // Expected-output timeline indexed by the cycle count after each rising edge.
  bit [7:0]  exp_sel    [DEPTH];
  bit        exp_tout   [DEPTH];
  bit        exp_xfer   [DEPTH];
  bit        exp_err    [DEPTH];
  bit [31:0] exp_dbus   [DEPTH];
  bit        exp_inc    [DEPTH];
  bit        exp_rstcnt [DEPTH];

  opb_reg_slave_arb dut (
    .OPB_Clk    (clk),
    .OPB_Rst    (rst),
    .OPB_ABus   (abus),
    .OPB_BE     (be),
    .OPB_DBus   (dbus_m),
    .OPB_RNW    (rnw),
    .OPB_select (sel),
    .OPB_seqAddr(seq),
    .Sl_DBus    (sl_dbus),
    .Sl_errAck  (sl_err),
    .Sl_retry   (sl_retry),
    .Sl_toutSup (sl_tout),
    .Sl_xferAck (sl_xfer),
    .S_select   (s_sel),
    .S_ABus     (s_abus),
    .S_DBus     (s_dbus),
    .S_BE       (s_be),
    .S_RNW      (s_rnw),
    .S_rdata    (s_rdata),
    .S_xferAck  (s_ack),
    .err_count  (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cyc < DEPTH) begin
        if (exp_rstcnt[cyc]) model_cnt = 0;
        if (exp_inc[cyc] && model_cnt != 65535) model_cnt++;
        chk("xferAck",  32'(sl_xfer),  32'(exp_xfer[cyc]));
        chk("errAck",   32'(sl_err),   32'(exp_err[cyc]));
        chk("Sl_DBus",  32'(sl_dbus),  exp_dbus[cyc]);
        chk("S_select", 32'(s_sel),    32'(exp_sel[cyc]));
        chk("toutSup",  32'(sl_tout),  32'(exp_tout[cyc]));
        chk("retry",    32'(sl_retry), 32'd0);
        chk("errcount", 32'(err_cnt),  32'(model_cnt));
      end
    end
  end

  // One master access; ack_slot<0 means no slave answers, abort_k>0 drops select early.
  task automatic txn(input string name, input logic [31:0] addr, input bit is_rd,
                     input logic [31:0] wdata, input logic [3:0] bev, input logic [7:0] sel_lit,
                     input int ack_slot, input int a, input logic [31:0] rdata,
                     input int stray, input int abort_k);
    int  c, h, fin, stop;
    bit  acked;
    @(posedge clk); #1;
    c = cyc;
    h = c + 1;
    for (int k = 0; k < 8; k++) begin
      s_rdata[32*k +: 32] = (k == ack_slot) ? rdata : (32'hA5A50000 | 32'(k));
    end
    abus = addr; dbus_m = wdata; be = bev; rnw = is_rd; sel = 1'b1;
    acked = (sel_lit != 8'h00) && (ack_slot >= 0) && (a <= TMO) && (abort_k == 0);
    fin   = (abort_k > 0) ? abort_k : (acked ? a : TMO);
    if (sel_lit != 8'h00) begin
      for (int i = h; i < h + fin; i++) begin
        exp_sel[i]  = sel_lit;
        exp_tout[i] = 1'b1;
      end
      if (abort_k == 0) begin
        if (acked) begin
          exp_xfer[h+fin] = 1'b1;
          exp_dbus[h+fin] = is_rd ? rdata : 32'h0;
        end else begin
          exp_err[h+fin] = 1'b1;
          exp_inc[h+fin] = 1'b1;
        end
      end
    end
    stop = h + fin + 2;
    for (int k = h; k <= stop; k++) begin
      @(posedge clk); #1;
      s_ack = '0;
      if (ack_slot >= 0 && k == h + a - 1) s_ack[ack_slot] = 1'b1;
      if (stray >= 0 && k == h) s_ack[stray] = 1'b1;
      if (k == h) begin
        chk({name, "_sel"}, 32'(s_sel), 32'(sel_lit));
        if (sel_lit != 8'h00) begin
          chk({name, "_abus"}, 32'(s_abus), addr);
          chk({name, "_sdbus"}, 32'(s_dbus), wdata);
          chk({name, "_be"}, 32'(s_be), 32'(bev));
          chk({name, "_rnw"}, 32'(s_rnw), 32'(is_rd));
        end
      end
      if (abort_k > 0 && k == h + abort_k - 1) sel = 1'b0;
      if (k == h + fin) begin
        sel = 1'b0;
        if (sel_lit != 8'h00 && abort_k == 0) begin
          chk({name, "_xfer"}, 32'(sl_xfer), 32'(acked));
          chk({name, "_err"}, 32'(sl_err), 32'(!acked));
          chk({name, "_dbus"}, 32'(sl_dbus), (acked && is_rd) ? rdata : 32'h0);
        end
      end
    end
    sel = 1'b0;
    s_ack = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c, h;
    rst = 1'b1;
    abus = '0; be = '0; dbus_m = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
    s_rdata = '0; s_ack = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(s_sel), 32'h0);
    chk("rst_dbus", 32'(sl_dbus), 32'h0);
    chk("rst_errcnt", 32'(err_cnt), 32'h0);
    chk("rst_xfer", 32'(sl_xfer), 32'h0);
    rst = 1'b0;

    txn("rd3",   32'h010C0300, 1'b1, 32'h0,        4'hF, 8'h08, 3, 3,  32'hDEADBEEF, -1, 0);
    txn("wr1",   32'h010C0104, 1'b0, 32'h12345678, 4'hF, 8'h02, 1, 2,  32'h55AA55AA, -1, 0);
    txn("tmo5",  32'h010C0500, 1'b1, 32'h0,        4'hF, 8'h20, -1, 0, 32'h0,        -1, 0);
    chk("errcnt_after_tmo", 32'(err_cnt), 32'd1);
    txn("miss8", 32'h010C0800, 1'b1, 32'h0,        4'hF, 8'h00, 0, 2,  32'h11111111, -1, 0);
    txn("missB", 32'h010B0000, 1'b1, 32'h0,        4'hF, 8'h00, 0, 2,  32'h22222222, -1, 0);
    txn("edge2", 32'h010C0200, 1'b1, 32'h0,        4'hF, 8'h04, 2, 16, 32'h2222AAAA, 5, 0);
    chk("errcnt_after_edge", 32'(err_cnt), 32'd1);
    txn("abrt6", 32'h010C0600, 1'b1, 32'h0,        4'hF, 8'h40, -1, 0, 32'h0,        -1, 3);
    chk("errcnt_after_abort", 32'(err_cnt), 32'd1);

    // Reset in the middle of an ACTIVE access to slot 2.
    @(posedge clk); #1;
    c = cyc;
    h = c + 1;
    abus = 32'h010C0200; rnw = 1'b1; dbus_m = '0; be = 4'hF; sel = 1'b1;
    for (int i = h; i < h + 3; i++) begin
      exp_sel[i]  = 8'h04;
      exp_tout[i] = 1'b1;
    end
    exp_rstcnt[h+3] = 1'b1;
    while (cyc < h + 3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sel = 1'b0;
    #1;
    chk("rst_mid_sel", 32'(s_sel), 32'h0);
    chk("rst_mid_errcnt", 32'(err_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    txn("rd0",   32'h010C0000, 1'b1, 32'h0,        4'hF, 8'h01, 0, 1,  32'hCAFEF00D, -1, 0);
    txn("rd7",   32'h010C07FC, 1'b1, 32'h0,        4'h3, 8'h80, 7, 4,  32'h0BADCAFE, -1, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
